data_memory_hs: RTL and testbench

DATA_MEMORY_HS -- requirements
Module: data_memory_hs

---
 rtl/data_memory_hs.sv | 118 +++++++++++
 tb/tb_data_memory_hs.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/data_memory_hs.sv
// data_memory_hs: single-port word memory behind a req/ready, rvalid handshake with WAIT_CYCLES wait states.
// Defining DMEM_MISALIGN_CHK_EN flags misaligned accesses on err_o and suppresses their effect.
module data_memory_hs #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 32,
   parameter int ADDR_W      = 32,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [DATA_W/8-1:0] be_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   output logic                ready_o,
   output logic                rvalid_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic                err_o
);
   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(DEPTH);
   localparam bit DIRECT = (WAIT_CYCLES == 0);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]        r_state;
   logic [3:0]        r_wcnt;
   logic              r_err;
   logic              r_we;
   logic              r_mis;
   logic [NB-1:0]     r_be;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_accept;
   logic              w_enter_resp;
   logic              w_mis_i;
   logic [IDX_W-1:0]  w_idx_i;
   logic              w_op_we;
   logic              w_op_mis;
   logic [NB-1:0]     w_op_be;
   logic [IDX_W-1:0]  w_op_idx;
   logic [DATA_W-1:0] w_op_wdata;
   logic              w_unused_addr;

   assign ready_o  = (r_state != S_WAIT);
   assign rvalid_o = (r_state == S_RESP);
   assign err_o    = rvalid_o & r_err;

   // Gated by reset so a request held during reset cannot touch the array.
   assign w_accept = rst_n_i & req_i & ready_o;
   assign w_idx_i  = IDX_W'(addr_i >> OFF_W);

`ifdef DMEM_MISALIGN_CHK_EN
   assign w_mis_i = |(addr_i & ADDR_W'(NB - 1));
`else
   assign w_mis_i = 1'b0;
`endif
   assign w_unused_addr = ^addr_i;

   // With no wait states the access completes on its acceptance edge, so live inputs are used.
   assign w_op_we      = DIRECT ? we_i    : r_we;
   assign w_op_mis     = DIRECT ? w_mis_i : r_mis;
   assign w_op_be      = DIRECT ? be_i    : r_be;
   assign w_op_idx     = DIRECT ? w_idx_i : r_idx;
   assign w_op_wdata   = DIRECT ? wdata_i : r_wdata;
   assign w_enter_resp = DIRECT ? w_accept : ((r_state == S_WAIT) && (r_wcnt == '0));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= S_IDLE;
         r_wcnt  <= '0;
         r_err   <= 1'b0;
         rdata_o <= '0;
      end else begin
         if (w_accept) begin
            if (DIRECT) begin
               r_state <= S_RESP;
            end else begin
               r_state <= S_WAIT;
               r_wcnt  <= 4'(WAIT_CYCLES - 1);
            end
         end else if (r_state == S_WAIT) begin
            if (r_wcnt == '0) r_state <= S_RESP;
            else              r_wcnt  <= r_wcnt - 4'd1;
         end else begin
            r_state <= S_IDLE;
         end
         if (w_enter_resp) begin
            r_err <= w_op_mis;
            if (!w_op_we && !w_op_mis) rdata_o <= r_mem[w_op_idx];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_we    <= we_i;
         r_mis   <= w_mis_i;
         r_be    <= be_i;
         r_idx   <= w_idx_i;
         r_wdata <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_enter_resp && w_op_we && !w_op_mis) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (w_op_be[b]) r_mem[w_op_idx][8*b +: 8] <= w_op_wdata[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_data_memory_hs.sv
// Directed bench for data_memory_hs: one instance with no wait states, one with three.
// Expectations follow DMEM_MISALIGN_CHK_EN when it is defined for the build.
module tb_data_memory_hs;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req3, we;
   logic [3:0]  be;
   logic [31:0] addr, wdata;
   logic        rdy0, rv0, err0, rdy3, rv3, err3;
   logic [31:0] rd0, rd3;
   int unsigned nvec = 0;
   int unsigned nmis = 0;

`ifdef DMEM_MISALIGN_CHK_EN
   localparam bit MIS_CHK = 1'b1;
`else
   localparam bit MIS_CHK = 1'b0;
`endif

   always #5 clk = ~clk;

   data_memory_hs #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .WAIT_CYCLES(0)) dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .req_i(req0), .we_i(we), .be_i(be), .addr_i(addr),
      .wdata_i(wdata), .ready_o(rdy0), .rvalid_o(rv0), .rdata_o(rd0), .err_o(err0));

   data_memory_hs #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .WAIT_CYCLES(3)) dut3 (
      .clk_i(clk), .rst_n_i(rst_n), .req_i(req3), .we_i(we), .be_i(be), .addr_i(addr),
      .wdata_i(wdata), .ready_o(rdy3), .rvalid_o(rv3), .rdata_o(rd3), .err_o(err3));

   // Issues one access to dut0 and returns one step after its acceptance edge.
   task automatic do0(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
      req0 = 1'b1; we = w; be = b; addr = a; wdata = d;
      @(posedge clk); #1;
      req0 = 1'b0; we = ~w; addr = 32'hFFFF_FFFC; wdata = ~d;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req0 = 1'b0; req3 = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      nvec++; if (rdy0 !== 1'b1) begin nmis++; $display("FAIL rst_ready0 got %b exp 1", rdy0); end
      nvec++; if (rv0 !== 1'b0) begin nmis++; $display("FAIL rst_rvalid0 got %b exp 0", rv0); end
      nvec++; if (err0 !== 1'b0) begin nmis++; $display("FAIL rst_err0 got %b exp 0", err0); end
      nvec++; if (rd0 !== 32'h0) begin nmis++; $display("FAIL rst_rdata0 got %h exp 0", rd0); end
      nvec++; if (rdy3 !== 1'b1) begin nmis++; $display("FAIL rst_ready3 got %b exp 1", rdy3); end
      nvec++; if (rv3 !== 1'b0) begin nmis++; $display("FAIL rst_rvalid3 got %b exp 0", rv3); end
      nvec++; if (rd3 !== 32'h0) begin nmis++; $display("FAIL rst_rdata3 got %h exp 0", rd3); end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read;
      do0(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
      nvec++; if (rv0 !== 1'b1) begin nmis++; $display("FAIL wr_rvalid got %b exp 1", rv0); end
      nvec++; if (rdy0 !== 1'b1) begin nmis++; $display("FAIL wr_ready_resp got %b exp 1", rdy0); end
      nvec++; if (rd0 !== 32'h0) begin nmis++; $display("FAIL wr_rdata_hold got %h exp 0", rd0); end
      do0(1'b0, 4'h0, 32'h10, 32'h0);
      nvec++; if (rv0 !== 1'b1) begin nmis++; $display("FAIL rd_rvalid got %b exp 1", rv0); end
      nvec++; if (rd0 !== 32'hDEADBEEF) begin nmis++; $display("FAIL rd_data got %h exp deadbeef", rd0); end
      @(posedge clk); #1;
      nvec++; if (rv0 !== 1'b0) begin nmis++; $display("FAIL rvalid_pulse got %b exp 0", rv0); end
      nvec++; if (rd0 !== 32'hDEADBEEF) begin nmis++; $display("FAIL rdata_hold got %h exp deadbeef", rd0); end
   endtask

   task automatic test_byte_enable;
      do0(1'b1, 4'hF, 32'h4, 32'h11223344);
      do0(1'b1, 4'b0101, 32'h4, 32'hAABBCCDD);
      do0(1'b0, 4'h0, 32'h4, 32'h0);
      nvec++; if (rd0 !== 32'h11BB33DD) begin nmis++; $display("FAIL be_merge got %h exp 11bb33dd", rd0); end
      do0(1'b1, 4'h0, 32'h4, 32'hFFFFFFFF);
      nvec++; if (rv0 !== 1'b1) begin nmis++; $display("FAIL be0_rvalid got %b exp 1", rv0); end
      do0(1'b0, 4'h0, 32'h4, 32'h0);
      nvec++; if (rd0 !== 32'h11BB33DD) begin nmis++; $display("FAIL be0_nochange got %h exp 11bb33dd", rd0); end
   endtask

   task automatic test_wrap;
      do0(1'b1, 4'hF, 32'h80, 32'h5);
      do0(1'b0, 4'h0, 32'h0, 32'h0);
      nvec++; if (rd0 !== 32'h5) begin nmis++; $display("FAIL wrap got %h exp 5", rd0); end
      @(posedge clk); #1;
   endtask

   // op 0 writes 0x8 while a stray write request is held through WAIT; op 1 reads it back.
   task automatic test_wait;
      for (int op = 0; op < 2; op++) begin
         req3 = 1'b1; we = (op == 0); be = 4'hF; addr = 32'h8; wdata = 32'hA5A50001;
         @(posedge clk); #1;
         we = 1'b1; wdata = 32'h0BAD0BAD; req3 = (op == 0);
         for (int i = 1; i <= 3; i++) begin
            nvec++; if (rdy3 !== 1'b0) begin nmis++; $display("FAIL wait_ready op%0d c%0d got %b exp 0", op, i, rdy3); end
            nvec++; if (rv3 !== 1'b0) begin nmis++; $display("FAIL wait_rvalid op%0d c%0d got %b exp 0", op, i, rv3); end
            if (i == 3) req3 = 1'b0;
            @(posedge clk); #1;
         end
         nvec++; if (rv3 !== 1'b1) begin nmis++; $display("FAIL wait_done op%0d got %b exp 1", op, rv3); end
         nvec++; if (rdy3 !== 1'b1) begin nmis++; $display("FAIL resp_ready op%0d got %b exp 1", op, rdy3); end
         if (op == 1) begin
            nvec++; if (rd3 !== 32'hA5A50001) begin nmis++; $display("FAIL wait_rdata got %h exp a5a50001", rd3); end
         end
         @(posedge clk); #1;
         nvec++; if (rv3 !== 1'b0) begin nmis++; $display("FAIL wait_pulse op%0d got %b exp 0", op, rv3); end
      end
   endtask

   task automatic test_reset_in_wait;
      req3 = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h8; wdata = 32'h12345678;
      @(posedge clk); #1;
      req3 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0; #1;
      nvec++; if (rdy3 !== 1'b1) begin nmis++; $display("FAIL rstw_ready got %b exp 1", rdy3); end
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         nvec++; if (rv3 !== 1'b0) begin nmis++; $display("FAIL rstw_norvalid c%0d got %b exp 0", i, rv3); end
      end
      req3 = 1'b1; we = 1'b0; addr = 32'h8;
      @(posedge clk); #1;
      req3 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      nvec++; if (rv3 !== 1'b1) begin nmis++; $display("FAIL rstw_read_rvalid got %b exp 1", rv3); end
      nvec++; if (rd3 !== 32'hA5A50001) begin nmis++; $display("FAIL rstw_old_data got %h exp a5a50001", rd3); end
      @(posedge clk); #1;
   endtask

   task automatic test_misalign;
      do0(1'b1, 4'hF, 32'h2, 32'h77);
      nvec++; if (rv0 !== 1'b1) begin nmis++; $display("FAIL mis_rvalid got %b exp 1", rv0); end
      nvec++; if (err0 !== MIS_CHK) begin nmis++; $display("FAIL mis_err got %b exp %b", err0, MIS_CHK); end
      do0(1'b0, 4'h0, 32'h0, 32'h0);
      nvec++; if (rd0 !== (MIS_CHK ? 32'h5 : 32'h77)) begin
         nmis++; $display("FAIL mis_storage got %h exp %h", rd0, (MIS_CHK ? 32'h5 : 32'h77));
      end
      nvec++; if (err0 !== 1'b0) begin nmis++; $display("FAIL aligned_err got %b exp 0", err0); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_byte_enable;
      test_wrap;
      test_wait;
      test_reset_in_wait;
      test_misalign;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
